// File: rtl/rei_pkg.sv
// Shared types and constants for the rei pipeline front end.
package rei_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  // Instruction-address-misaligned exception code
  localparam logic [3:0] CAUSE_MISALIGNED_FETCH = 4'd0;

  typedef struct packed {
    logic            valid;
    logic [3:0]      cause;
    logic [XLEN-1:0] tval;
  } exc_s;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] ir;
    exc_s            exc;
  } fetch_entry_s;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/rei_fifo.sv
// Register-based fetch-entry queue with flush, count and push/pop.
// A flush empties the queue; a push in the same cycle lands in the
// emptied queue, a pop in the same cycle is ignored.
module rei_fifo
  import rei_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_s             push_data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output fetch_entry_s             head_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FULL = (AW + 1)'(Depth);

  fetch_entry_s  r_mem [Depth];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_count;

  logic          w_pop;
  logic [AW-1:0] w_wr_idx;

  assign w_pop    = pop_i & ~flush_i & (r_count != '0);
  assign w_wr_idx = flush_i ? '0 : r_wptr;

  // Entry storage, written on push only
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[w_wr_idx] <= push_data_i;
  end

  // Read/write pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_rptr  <= '0;
      r_wptr  <= push_i ? AW'(1) : '0;
      r_count <= push_i ? (AW + 1)'(1) : '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + (AW + 1)'(push_i) - (AW + 1)'(w_pop);
    end
  end

  assign valid_o = (r_count != '0);
  assign head_o  = r_mem[r_rptr];
  assign count_o = r_count;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (push_i && !flush_i && !w_pop) |-> (r_count != FULL));

endmodule

// File: rtl/rei_fetch.sv
// Instruction-fetch front end: ibus read master with multiple outstanding
// reads, credit-limited instruction queue, redirect with stale-response
// discard and a halting misaligned-target exception path.
module rei_fetch
  import rei_pkg::*;
#(
  parameter int              Depth          = 4,
  parameter int              MaxOutstanding = 2,
  parameter logic [XLEN-1:0] ResetVector    = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic            ibus_arvalid_o,
  input  logic            ibus_arready_i,
  output logic [XLEN-1:0] ibus_araddr_o,
  input  logic            ibus_rvalid_i,
  input  logic [ILEN-1:0] ibus_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            id_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [ILEN-1:0] id_ir_o,
  output exc_s            id_exc_o
);

  localparam int CW = $clog2(Depth) + 1;
  localparam int OW = $clog2(MaxOutstanding + 1);

  logic            r_arvalid;
  logic [XLEN-1:0] r_araddr;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_resp_pc;
  logic [OW-1:0]   r_out;
  logic [OW-1:0]   r_discard;
  logic            r_stale;
  logic            r_halt;

  logic            w_accept;
  logic            w_hold;
  logic            w_misaligned;
  logic            w_drop;
  logic            w_push_rsp;
  logic            w_pop;
  logic            w_fifo_push;
  logic            w_head_valid;
  fetch_entry_s    w_push_data;
  fetch_entry_s    w_head;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_count_nxt;
  logic [OW-1:0]   w_out_nxt;
  logic [OW-1:0]   w_disc_nxt;
  logic            w_stale_nxt;
  logic            w_halt_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_resp_pc_nxt;
  logic            w_issue;

  assign w_accept     = r_arvalid & ibus_arready_i;
  assign w_hold       = r_arvalid & ~ibus_arready_i;
  assign w_misaligned = redirect_i & is_misaligned(redirect_pc_i);
  // Responses belonging to the pre-redirect stream never reach the queue
  assign w_drop       = ibus_rvalid_i & (redirect_i | (r_discard != '0));
  assign w_push_rsp   = ibus_rvalid_i & ~w_drop;
  assign w_pop        = w_head_valid & id_ready_i & ~redirect_i;
  assign w_fifo_push  = redirect_i ? w_misaligned : w_push_rsp;

  // Queue entry: either the faulting redirect target or a returned instruction
  always_comb begin
    w_push_data = '0;
    if (redirect_i) begin
      w_push_data.pc        = redirect_pc_i;
      w_push_data.exc.valid = 1'b1;
      w_push_data.exc.cause = CAUSE_MISALIGNED_FETCH;
      w_push_data.exc.tval  = redirect_pc_i;
    end else begin
      w_push_data.pc = r_resp_pc;
      w_push_data.ir = ibus_rdata_i;
    end
  end

  // Next-state bookkeeping; a redirect overrides all other updates
  always_comb begin
    w_out_nxt = r_out + OW'(w_accept) - OW'(ibus_rvalid_i);
    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old stream
      w_disc_nxt    = w_out_nxt;
      w_stale_nxt   = w_hold;
      w_halt_nxt    = w_misaligned;
      w_pc_nxt      = redirect_pc_i;
      w_resp_pc_nxt = redirect_pc_i;
      w_count_nxt   = CW'(w_misaligned);
    end else begin
      w_disc_nxt    = r_discard + OW'(w_accept & r_stale) - OW'(w_drop);
      w_stale_nxt   = r_stale & ~w_accept;
      w_halt_nxt    = r_halt;
      // A stale request was issued for the old stream, so it does not advance pc
      w_pc_nxt      = (w_accept & ~r_stale) ? r_pc + XLEN'(4) : r_pc;
      w_resp_pc_nxt = w_push_rsp ? r_resp_pc + XLEN'(4) : r_resp_pc;
      w_count_nxt   = w_count + CW'(w_push_rsp) - CW'(w_pop);
    end
    // Credit rule: every in-flight read already owns a queue slot
    w_issue = !w_halt_nxt
           && (32'(w_out_nxt) < 32'(MaxOutstanding))
           && (32'(w_count_nxt) + 32'(w_out_nxt) < 32'(Depth));
  end

  // Fetch state and the registered read-request channel
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_arvalid <= 1'b0;
      r_araddr  <= ResetVector;
      r_pc      <= ResetVector;
      r_resp_pc <= ResetVector;
      r_out     <= '0;
      r_discard <= '0;
      r_stale   <= 1'b0;
      r_halt    <= 1'b0;
    end else begin
      r_out     <= w_out_nxt;
      r_discard <= w_disc_nxt;
      r_stale   <= w_stale_nxt;
      r_halt    <= w_halt_nxt;
      r_pc      <= w_pc_nxt;
      r_resp_pc <= w_resp_pc_nxt;
      if (w_hold) begin
        r_arvalid <= 1'b1;
      end else begin
        r_arvalid <= w_issue;
        if (w_issue) r_araddr <= w_pc_nxt;
      end
    end
  end

  rei_fifo #(
    .Depth(Depth)
  ) u_queue (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (redirect_i),
    .push_i     (w_fifo_push),
    .push_data_i(w_push_data),
    .pop_i      (w_pop),
    .valid_o    (w_head_valid),
    .head_o     (w_head),
    .count_o    (w_count)
  );

  assign ibus_arvalid_o = r_arvalid;
  assign ibus_araddr_o  = r_araddr;
  assign id_valid_o     = w_head_valid;
  assign id_pc_o        = w_head_valid ? w_head.pc  : '0;
  assign id_ir_o        = w_head_valid ? w_head.ir  : '0;
  assign id_exc_o       = w_head_valid ? w_head.exc : '0;

  a_rsp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    ibus_rvalid_i |-> (r_out != '0));

  a_araddr_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    r_arvalid |-> (r_araddr[1:0] == 2'b00));

endmodule

// File: tb/tb_rei_fetch.sv
// Directed testbench for rei_fetch with an in-order ibus responder.
// Responder returns rdata = ~address, so every entry's ir is checkable.
module tb_rei_fetch;
  import rei_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        arvalid;
  logic        ar_rdy;
  logic [31:0] araddr;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_rdy;
  logic [31:0] id_pc;
  logic [31:0] id_ir;
  exc_s        id_exc;
  logic        rsp_en;

  int          checks = 0;
  int          errors = 0;
  int          acc_cnt = 0;
  logic [31:0] acc_q[$];
  exc_s        zero_exc = '0;

  always #5 clk = ~clk;

  rei_fetch #(.Depth(4), .MaxOutstanding(2), .ResetVector(32'h0)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ibus_arvalid_o(arvalid),
    .ibus_arready_i(ar_rdy),
    .ibus_araddr_o (araddr),
    .ibus_rvalid_i (rvalid),
    .ibus_rdata_i  (rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_valid_o    (id_valid),
    .id_ready_i    (id_rdy),
    .id_pc_o       (id_pc),
    .id_ir_o       (id_ir),
    .id_exc_o      (id_exc)
  );

  // Bus slave: record accepts at the edge, answer one cycle later in order
  always @(posedge clk) begin
    if (!rst && arvalid && ar_rdy) begin
      acc_q.push_back(araddr);
      acc_cnt++;
    end
    #1;
    if (rst) begin
      acc_q.delete();
      rvalid = 1'b0;
    end else if (rsp_en && acc_q.size() > 0) begin
      rvalid = 1'b1;
      rdata  = ~acc_q.pop_front();
    end else begin
      rvalid = 1'b0;
    end
  end

  task automatic do_reset(input logic rdy_id);
    @(negedge clk);
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
    ar_rdy = 1'b1; rsp_en = 1'b1; id_rdy = rdy_id;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b0 || araddr !== 32'h0) begin
      errors++; $display("FAIL reset_bus: arvalid=%b araddr=%h, want 0/00000000", arvalid, araddr);
    end
    checks++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_ir !== 32'h0 || id_exc !== zero_exc) begin
      errors++; $display("FAIL reset_id: valid=%b pc=%h ir=%h exc=%h, want all zero", id_valid, id_pc, id_ir, id_exc);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h0) begin
      errors++; $display("FAIL first_arvalid: arvalid=%b araddr=%h, want 1/00000000", arvalid, araddr);
    end
  endtask

  task automatic test_stream;
    logic [31:0] exp;
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h4) begin
      errors++; $display("FAIL stream_araddr: arvalid=%b araddr=%h, want 1/00000004", arvalid, araddr);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      exp = 32'(4 * i);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== exp || id_ir !== ~exp || id_exc !== zero_exc) begin
        errors++; $display("FAIL stream[%0d]: valid=%b pc=%h ir=%h, want 1 pc=%h ir=%h", i, id_valid, id_pc, id_ir, exp, ~exp);
      end
    end
  endtask

  task automatic test_backpressure;
    int base;
    int k;
    logic [31:0] exp;
    do_reset(1'b0);
    base = acc_cnt;
    repeat (12) @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || arvalid !== 1'b0) begin
      errors++; $display("FAIL bp_stall: valid=%b pc=%h arvalid=%b, want 1/00000000/0", id_valid, id_pc, arvalid);
    end
    checks++;
    if (acc_cnt - base !== 4) begin
      errors++; $display("FAIL bp_requests: %0d reads accepted, want 4", acc_cnt - base);
    end
    id_rdy = 1'b1;
    k = 0;
    for (int n = 0; n < 40 && k < 6; n++) begin
      if (id_valid) begin
        exp = 32'(4 * k);
        checks++;
        if (id_pc !== exp || id_ir !== ~exp) begin
          errors++; $display("FAIL bp_drain[%0d]: pc=%h ir=%h, want pc=%h ir=%h", k, id_pc, id_ir, exp, ~exp);
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 6) begin
      errors++; $display("FAIL bp_drain_count: got %0d entries, want 6", k);
    end
  endtask

  task automatic test_redirect_outstanding;
    int n;
    int k;
    logic [31:0] exp;
    do_reset(1'b1);
    n = 0;
    while (!(arvalid && araddr == 32'h10) && n < 40) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 40) begin
      errors++; $display("FAIL ro_reach: araddr never reached 00000010 (last %h)", araddr);
    end
    rsp_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (arvalid !== 1'b0 || acc_q.size() != 2) begin
      errors++; $display("FAIL ro_limit: arvalid=%b outstanding=%0d, want 0/2", arvalid, acc_q.size());
    end else begin
      checks++;
      if (acc_q[0] !== 32'h10 || acc_q[1] !== 32'h14) begin
        errors++; $display("FAIL ro_addrs: %h %h, want 00000010 00000014", acc_q[0], acc_q[1]);
      end
    end
    redirect = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect = 1'b0; rsp_en = 1'b1;
    k = 0;
    for (int m = 0; m < 40 && k < 2; m++) begin
      if (id_valid) begin
        exp = 32'h100 + 32'(4 * k);
        checks++;
        if (id_pc !== exp || id_ir !== ~exp) begin
          errors++; $display("FAIL ro_target[%0d]: pc=%h ir=%h, want pc=%h ir=%h", k, id_pc, id_ir, exp, ~exp);
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 2) begin
      errors++; $display("FAIL ro_count: got %0d entries, want 2", k);
    end
  endtask

  task automatic test_stale;
    int n;
    int k;
    logic [31:0] exp;
    do_reset(1'b1);
    n = 0;
    while (!(arvalid && araddr == 32'h20) && n < 40) begin
      @(negedge clk); n++;
    end
    ar_rdy = 1'b0;
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h20) begin
      errors++; $display("FAIL stale_pre: arvalid=%b araddr=%h, want 1/00000020", arvalid, araddr);
    end
    redirect = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h20) begin
      errors++; $display("FAIL stale_hold: arvalid=%b araddr=%h, want 1/00000020", arvalid, araddr);
    end
    @(negedge clk);
    ar_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (arvalid !== 1'b1 || araddr !== 32'h200) begin
      errors++; $display("FAIL stale_next: arvalid=%b araddr=%h, want 1/00000200", arvalid, araddr);
    end
    k = 0;
    for (int m = 0; m < 40 && k < 2; m++) begin
      if (id_valid) begin
        exp = 32'h200 + 32'(4 * k);
        checks++;
        if (id_pc !== exp || id_ir !== ~exp) begin
          errors++; $display("FAIL stale_target[%0d]: pc=%h ir=%h, want pc=%h ir=%h", k, id_pc, id_ir, exp, ~exp);
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 2) begin
      errors++; $display("FAIL stale_count: got %0d entries, want 2", k);
    end
  endtask

  task automatic test_misaligned;
    int base;
    int k;
    logic [31:0] exp;
    do_reset(1'b0);
    repeat (12) @(negedge clk);
    base = acc_cnt;
    redirect = 1'b1; redirect_pc = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h102 || id_ir !== 32'h0) begin
      errors++; $display("FAIL mis_entry: valid=%b pc=%h ir=%h, want 1/00000102/00000000", id_valid, id_pc, id_ir);
    end
    checks++;
    if (id_exc.valid !== 1'b1 || id_exc.cause !== CAUSE_MISALIGNED_FETCH || id_exc.tval !== 32'h102) begin
      errors++; $display("FAIL mis_exc: valid=%b cause=%0d tval=%h, want 1/%0d/00000102", id_exc.valid, id_exc.cause, id_exc.tval, CAUSE_MISALIGNED_FETCH);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (arvalid !== 1'b0 || acc_cnt != base) begin
      errors++; $display("FAIL mis_halt: arvalid=%b new_reads=%0d, want 0/0", arvalid, acc_cnt - base);
    end
    id_rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (id_valid !== 1'b0) begin
      errors++; $display("FAIL mis_single: valid=%b pc=%h after pop, want empty queue", id_valid, id_pc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (arvalid !== 1'b0 || acc_cnt != base) begin
      errors++; $display("FAIL mis_still_halted: arvalid=%b new_reads=%0d, want 0/0", arvalid, acc_cnt - base);
    end
    redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    k = 0;
    for (int m = 0; m < 40 && k < 2; m++) begin
      if (id_valid) begin
        exp = 32'h300 + 32'(4 * k);
        checks++;
        if (id_pc !== exp || id_ir !== ~exp || id_exc !== zero_exc) begin
          errors++; $display("FAIL mis_restart[%0d]: pc=%h ir=%h exc=%h, want pc=%h ir=%h no exc", k, id_pc, id_ir, id_exc, exp, ~exp);
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 2) begin
      errors++; $display("FAIL mis_restart_count: got %0d entries, want 2", k);
    end
  endtask

  task automatic test_same_cycle;
    int k;
    logic [31:0] exp;
    do_reset(1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (id_valid !== 1'b1 || rvalid !== 1'b1) begin
      errors++; $display("FAIL sc_setup: id_valid=%b rvalid=%b, want 1/1", id_valid, rvalid);
    end
    redirect = 1'b1; redirect_pc = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || arvalid !== 1'b1 || araddr !== 32'h400) begin
      errors++; $display("FAIL sc_flush: id_valid=%b arvalid=%b araddr=%h, want 0/1/00000400", id_valid, arvalid, araddr);
    end
    k = 0;
    for (int m = 0; m < 40 && k < 3; m++) begin
      if (id_valid) begin
        exp = 32'h400 + 32'(4 * k);
        checks++;
        if (id_pc !== exp || id_ir !== ~exp) begin
          errors++; $display("FAIL sc_target[%0d]: pc=%h ir=%h, want pc=%h ir=%h", k, id_pc, id_ir, exp, ~exp);
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 3) begin
      errors++; $display("FAIL sc_count: got %0d entries, want 3", k);
    end
  endtask

  task automatic test_wrap;
    int k;
    logic [31:0] exp;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    redirect = 1'b0;
    k = 0;
    for (int m = 0; m < 40 && k < 4; m++) begin
      if (id_valid) begin
        exp = 32'hFFFF_FFF8 + 32'(4 * k);
        checks++;
        if (id_pc !== exp || id_ir !== ~exp) begin
          errors++; $display("FAIL wrap[%0d]: pc=%h ir=%h, want pc=%h ir=%h", k, id_pc, id_ir, exp, ~exp);
        end
        k++;
      end
      @(negedge clk);
    end
    checks++;
    if (k != 4) begin
      errors++; $display("FAIL wrap_count: got %0d entries, want 4", k);
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;
    ar_rdy = 1'b1; rsp_en = 1'b1; id_rdy = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_stale();
    test_misaligned();
    test_same_cycle();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rei_fetch.md
Name: rei_fetch

Overview:
Parametrised instruction-fetch front end for the next-generation rei pipeline. The current core fetches combinationally from npc and has no stall path. This block replaces that path with three pieces:
- a valid/ready instruction-bus master that supports multiple outstanding reads;
- a configurable-depth instruction queue;
- redirect handling with stale-response discard.
It sits between the ibus and the Id stage. The Cm stage drives its redirect input on branch mispredict, trap or mret.

Parameters:
XLEN, 32, data/address width (from rei_pkg)
ILEN, 32, instruction width (from rei_pkg)
Depth, 4, instruction queue entries (power of two, >=2)
MaxOutstanding, 2, max accepted-but-unanswered ibus reads (>=1)
ResetVector, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
ibus_arvalid_o  out  1  read request valid
ibus_arready_i  in  1  read request accepted
ibus_araddr_o  out  XLEN  request address, word aligned
ibus_rvalid_i  in  1  read response valid (in order, one per accepted request)
ibus_rdata_i  in  ILEN  response instruction
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  XLEN  restart address
id_valid_o  out  1  queue head valid
id_ready_i  in  1  Id consumes head
id_pc_o  out  XLEN  head pc
id_ir_o  out  ILEN  head instruction
id_exc_o  out  exc_s  head exception (instruction-address-misaligned only)

Behaviour:
- Reset is asynchronous and active-high.
  - Reset values: arvalid 0, araddr ResetVector, id_valid 0, id_pc 0, id_ir 0, id_exc 0.
  - Internal state: queue empty, outstanding 0, discard 0, stale 0, halt 0, fetch pc ResetVector.
  - Reset mid-transaction drops everything; in-flight responses after reset are the bus owner's problem (the bus is reset too).
- Issue condition: arvalid asserts when all of the following hold:
  - !halt;
  - outstanding < MaxOutstanding;
  - count + outstanding < Depth (credit rule, so a response can never overflow the queue).
- First arvalid occurs in the first cycle after rst_i deasserts.
- Once asserted, arvalid and araddr hold stable until arready.
- On arvalid && arready: fetch pc += 4 and outstanding += 1. If stale is set, the request is counted into discard instead and stale clears.
- Response handling on rvalid:
  - outstanding -= 1;
  - if discard > 0: drop the response, discard -= 1;
  - else push {resp_pc, rdata, exc=0} and resp_pc += 4.
- Queue timing:
  - the queue is registered; a push is visible on id_* the next cycle (response-to-id latency 1);
  - pop on id_valid && id_ready;
  - push and pop in the same cycle are both performed, and count is unchanged.
- Redirect (wins over everything in the same cycle):
  - queue cleared; a pop in the same cycle is ignored;
  - discard = outstanding + (accept this cycle ? 1 : 0) - (rvalid this cycle ? 1 : 0) + (discard-side adjustments); any rvalid in the redirect cycle is itself discarded;
  - if arvalid && !arready: the request stays on the bus unchanged and stale is set;
  - fetch pc and resp_pc load redirect_pc;
  - halt clears;
  - new requests start the cycle after the stale request is accepted, or the next cycle if none is stale.
- Misaligned redirect (redirect_pc[1:0] != 0):
  - no bus request is issued; halt is set;
  - one queue entry is pushed: pc = redirect_pc, ir 0, exc.valid 1, cause CAUSE_MISALIGNED_FETCH, tval redirect_pc;
  - only the next redirect clears halt.
- Wrap-around: pc += 4 wraps modulo 2^XLEN with no special handling.
- Assertions:
  - rvalid with outstanding == 0 is illegal;
  - a push into a full queue is illegal;
  - araddr[1:0] must be 0 while arvalid is high.

Decomposition:
- rei_pkg gains:
  - CAUSE_MISALIGNED_FETCH;
  - a fetch-entry typedef: struct of pc, ir, exc_s.
- Sub-module: rei_fifo, a parametrised Depth x entry register FIFO with flush, count output, and push/pop.

Test Plan:
- Reset with zero-wait bus (arready=1, rvalid one cycle after accept), id_ready=1 → arvalid in the first cycle after reset; id_pc sequence 0x0, 0x4, 0x8, …; one instruction per cycle at steady state.
- id_ready=0, Depth=4, MaxOutstanding=2 → exactly 4 entries queued, arvalid drops with count+outstanding=4, no overflow; release id_ready → pcs 0x0–0xC in order, then fetch resumes.
- Two requests outstanding (0x10, 0x14) then redirect to 0x100 → both responses dropped; next id_pc is 0x100 with correct ir.
- arvalid for 0x20 held with arready=0, redirect to 0x200, arready=1 two cycles later → that response is dropped; araddr goes 0x20 then 0x200; first id_pc is 0x200.
- Redirect to 0x102 → no ibus request; one entry with pc 0x102, exc.cause CAUSE_MISALIGNED_FETCH, tval 0x102; fetch halts until a redirect to 0x300 restarts it.
- Redirect, rvalid and id pop all in the same cycle → the response is discarded, the pop is ignored, discard/outstanding counters stay consistent (the next valid entry is the redirect target).
